// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU function codes, datapath widths and the ID/EX register layout.
package cpu_pkg;
  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  // imm_ext already holds the final B immediate (lui / sign / zero extended)
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs_addr;
    logic [RW-1:0] rt_addr;
    logic [RW-1:0] rd_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm_ext;
    logic [4:0]    shamt;
    logic          alusrc1;
    logic          b_imm;
    logic [5:0]    alufun;
    logic          sign;
    logic          memread;
    logic          memwrite;
    logic          regwrite;
  } id_ex_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction in, forwarding sources, ALU operands and controls out.
interface id_ex_stage_if
  import cpu_pkg::*;
;
  logic          id_valid;
  logic [RW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic          id_uses_rs, id_uses_rt;
  logic [DW-1:0] id_rs_data, id_rt_data;
  logic [15:0]   id_imm16;
  logic [4:0]    id_shamt;
  logic          id_alusrc1, id_alusrc2, id_extop, id_luop;
  logic [5:0]    id_alufun;
  logic          id_sign, id_memread, id_memwrite, id_regwrite;
  logic          flush;
  logic          mem_regwrite;
  logic [RW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_result;
  logic          wb_regwrite;
  logic [RW-1:0] wb_rd_addr;
  logic [DW-1:0] wb_result;
  logic          stall;
  logic          ex_valid;
  logic [DW-1:0] ex_a, ex_b, ex_store_data;
  logic [5:0]    ex_alufun;
  logic          ex_sign;
  logic [RW-1:0] ex_rd_addr;
  logic          ex_memread, ex_memwrite, ex_regwrite;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm16, id_shamt, id_alusrc1, id_alusrc2,
           id_extop, id_luop, id_alufun, id_sign, id_memread, id_memwrite,
           id_regwrite, flush, mem_regwrite, mem_rd_addr, mem_result,
           wb_regwrite, wb_rd_addr, wb_result,
    input  stall, ex_valid, ex_a, ex_b, ex_alufun, ex_sign, ex_store_data,
           ex_rd_addr, ex_memread, ex_memwrite, ex_regwrite
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm16, id_shamt, id_alusrc1, id_alusrc2,
           id_extop, id_luop, id_alufun, id_sign, id_memread, id_memwrite,
           id_regwrite, flush, mem_regwrite, mem_rd_addr, mem_result,
           wb_regwrite, wb_rd_addr, wb_result,
    output stall, ex_valid, ex_a, ex_b, ex_alufun, ex_sign, ex_store_data,
           ex_rd_addr, ex_memread, ex_memwrite, ex_regwrite
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority operand forwarding: MEM result, then WB result, then register-file value.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_rd_addr,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] data
);
  logic mem_hit, wb_hit;

  // r0 is hardwired zero, so a write to it must never be forwarded
  assign mem_hit = mem_regwrite && (mem_rd_addr != '0) && (addr == mem_rd_addr);
  assign wb_hit  = wb_regwrite  && (wb_rd_addr  != '0) && (addr == wb_rd_addr);

  always_comb begin
    data = rf_data;
    if (mem_hit)     data = mem_result;
    else if (wb_hit) data = wb_result;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion and ALU operand resolution.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);
  id_ex_t        ex_q, ex_d;
  logic          hazard, live;
  logic [DW-1:0] fwd_rs, fwd_rt;

  assign hazard = ex_q.valid && ex_q.memread && (ex_q.rd_addr != '0) &&
                  ((bus.id_uses_rs && (bus.id_rs_addr == ex_q.rd_addr)) ||
                   (bus.id_uses_rt && (bus.id_rt_addr == ex_q.rd_addr)));
  assign bus.stall = hazard && bus.id_valid && !bus.flush;
  assign live      = bus.id_valid && !bus.stall && !bus.flush;

  always_comb begin
    ex_d         = '0;
    ex_d.rs_addr = bus.id_rs_addr;
    ex_d.rt_addr = bus.id_rt_addr;
    ex_d.rs_data = bus.id_rs_data;
    ex_d.rt_data = bus.id_rt_data;
    ex_d.shamt   = bus.id_shamt;
    ex_d.alusrc1 = bus.id_alusrc1;
    ex_d.b_imm   = bus.id_alusrc2 || bus.id_luop;
    ex_d.sign    = bus.id_sign;
    if (bus.id_luop)       ex_d.imm_ext = {bus.id_imm16, {(DW-16){1'b0}}};
    else if (bus.id_extop) ex_d.imm_ext = {{(DW-16){bus.id_imm16[15]}}, bus.id_imm16};
    else                   ex_d.imm_ext = {{(DW-16){1'b0}}, bus.id_imm16};
    // Anything that can change architectural state is zeroed in a bubble
    if (live) begin
      ex_d.valid    = 1'b1;
      ex_d.rd_addr  = bus.id_rd_addr;
      ex_d.alufun   = bus.id_alufun;
      ex_d.memread  = bus.id_memread;
      ex_d.memwrite = bus.id_memwrite;
      ex_d.regwrite = bus.id_regwrite;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  fwd_mux u_fwd_rs (
    .addr(ex_q.rs_addr), .rf_data(ex_q.rs_data),
    .mem_regwrite(bus.mem_regwrite), .mem_rd_addr(bus.mem_rd_addr), .mem_result(bus.mem_result),
    .wb_regwrite(bus.wb_regwrite), .wb_rd_addr(bus.wb_rd_addr), .wb_result(bus.wb_result),
    .data(fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .addr(ex_q.rt_addr), .rf_data(ex_q.rt_data),
    .mem_regwrite(bus.mem_regwrite), .mem_rd_addr(bus.mem_rd_addr), .mem_result(bus.mem_result),
    .wb_regwrite(bus.wb_regwrite), .wb_rd_addr(bus.wb_rd_addr), .wb_result(bus.wb_result),
    .data(fwd_rt)
  );

  assign bus.ex_a          = ex_q.alusrc1 ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_rs;
  assign bus.ex_b          = ex_q.b_imm ? ex_q.imm_ext : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_alufun     = ex_q.alufun;
  assign bus.ex_sign       = ex_q.sign;
  assign bus.ex_rd_addr    = ex_q.rd_addr;
  assign bus.ex_memread    = ex_q.memread;
  assign bus.ex_memwrite   = ex_q.memwrite;
  assign bus.ex_regwrite   = ex_q.regwrite;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, immediates, forwarding, load-use stall, flush, reset.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
    bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
    bus.id_imm16 = 0; bus.id_shamt = 0; bus.id_alusrc1 = 0; bus.id_alusrc2 = 0;
    bus.id_extop = 0; bus.id_luop = 0; bus.id_alufun = 0; bus.id_sign = 0;
    bus.id_memread = 0; bus.id_memwrite = 0; bus.id_regwrite = 0; bus.flush = 0;
    bus.mem_regwrite = 0; bus.mem_rd_addr = 0; bus.mem_result = 0;
    bus.wb_regwrite = 0; bus.wb_rd_addr = 0; bus.wb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lw rd, 0(r1)
  task automatic set_lw(input logic [4:0] rd);
    idle();
    bus.id_valid = 1; bus.id_rs_addr = 1; bus.id_rt_addr = rd; bus.id_rd_addr = rd;
    bus.id_uses_rs = 1; bus.id_alusrc2 = 1; bus.id_extop = 1; bus.id_alufun = ALU_ADD;
    bus.id_memread = 1; bus.id_regwrite = 1;
  endtask

  // add r5, r4, r6
  task automatic set_add_r4();
    idle();
    bus.id_valid = 1; bus.id_rs_addr = 4; bus.id_rt_addr = 6; bus.id_rd_addr = 5;
    bus.id_uses_rs = 1; bus.id_uses_rt = 1; bus.id_rs_data = 32'h1; bus.id_rt_data = 32'h2;
    bus.id_alufun = ALU_ADD; bus.id_regwrite = 1;
  endtask

  initial begin
    idle();
    #12;
    chk("rst_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("rst_ctrl", {29'b0, bus.ex_memread, bus.ex_memwrite, bus.ex_regwrite}, 32'h0);
    chk("rst_alufun", {26'b0, bus.ex_alufun}, 32'h0);
    chk("rst_a", bus.ex_a, 32'h0);
    reset = 0;

    // addi r2, r1, -1
    idle();
    bus.id_valid = 1; bus.id_rs_addr = 1; bus.id_rt_addr = 2; bus.id_rd_addr = 2;
    bus.id_uses_rs = 1; bus.id_rs_data = 5; bus.id_alusrc2 = 1; bus.id_extop = 1;
    bus.id_imm16 = 16'hFFFF; bus.id_alufun = ALU_ADD; bus.id_sign = 1; bus.id_regwrite = 1;
    step();
    chk("addi_a", bus.ex_a, 32'h5);
    chk("addi_b", bus.ex_b, 32'hFFFFFFFF);
    chk("addi_alufun", {26'b0, bus.ex_alufun}, 32'h0);
    chk("addi_ctrl", {25'b0, bus.ex_valid, bus.ex_sign, bus.ex_regwrite, bus.ex_rd_addr[3:0]}, 32'h72);

    // ori with zero extension
    bus.id_extop = 0; bus.id_alufun = ALU_OR; bus.id_sign = 0;
    step();
    chk("ori_b", bus.ex_b, 32'h0000FFFF);

    // rs = r3 forwarded: MEM beats WB, then WB alone
    idle();
    bus.id_valid = 1; bus.id_rs_addr = 3; bus.id_rd_addr = 8; bus.id_uses_rs = 1;
    bus.id_rs_data = 32'h55; bus.id_alufun = ALU_ADD; bus.id_regwrite = 1;
    step();
    bus.mem_regwrite = 1; bus.mem_rd_addr = 3; bus.mem_result = 32'h11;
    bus.wb_regwrite = 1; bus.wb_rd_addr = 3; bus.wb_result = 32'h22;
    #1 chk("fwd_mem_prio", bus.ex_a, 32'h11);
    bus.mem_regwrite = 0;
    #1 chk("fwd_wb", bus.ex_a, 32'h22);
    bus.wb_rd_addr = 4;
    #1 chk("fwd_none", bus.ex_a, 32'h55);

    // rs = r0 must never forward
    idle();
    bus.id_valid = 1; bus.id_rs_data = 32'h77; bus.id_alufun = ALU_ADD;
    step();
    bus.mem_regwrite = 1; bus.mem_rd_addr = 0; bus.mem_result = 32'h11;
    bus.wb_regwrite = 1; bus.wb_rd_addr = 0; bus.wb_result = 32'h22;
    #1 chk("fwd_r0", bus.ex_a, 32'h77);

    // id_valid=0 bubble ignores control inputs
    idle();
    bus.id_regwrite = 1; bus.id_memwrite = 1; bus.id_memread = 1; bus.id_alufun = ALU_SRA;
    step();
    chk("inv_bubble", {25'b0, bus.ex_valid, bus.ex_alufun}, 32'h0);
    chk("inv_ctrl", {29'b0, bus.ex_memread, bus.ex_memwrite, bus.ex_regwrite}, 32'h0);

    // load-use: one-cycle stall, bubble, then forward from MEM
    set_lw(4);
    step();
    set_add_r4();
    #1 chk("lu_stall", {31'b0, bus.stall}, 32'h1);
    step();
    chk("lu_bubble", {31'b0, bus.ex_valid}, 32'h0);
    chk("lu_stall_end", {31'b0, bus.stall}, 32'h0);
    step();
    bus.mem_regwrite = 1; bus.mem_rd_addr = 4; bus.mem_result = 32'h99;
    #1 chk("lu_fwd", bus.ex_a, 32'h99);
    chk("lu_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("lu_b", bus.ex_b, 32'h2);

    // load-use with flush: flush wins, no stall, bubble captured
    set_lw(4);
    step();
    set_add_r4();
    bus.flush = 1;
    #1 chk("flush_nostall", {31'b0, bus.stall}, 32'h0);
    step();
    chk("flush_bubble", {28'b0, bus.ex_valid, bus.ex_memread, bus.ex_memwrite, bus.ex_regwrite}, 32'h0);

    // lui r9, 0x1234
    idle();
    bus.id_valid = 1; bus.id_rd_addr = 9; bus.id_imm16 = 16'h1234; bus.id_luop = 1;
    bus.id_extop = 1; bus.id_alufun = ALU_ADD; bus.id_regwrite = 1;
    step();
    chk("lui_b", bus.ex_b, 32'h12340000);

    // sll r10, r11, 3
    idle();
    bus.id_valid = 1; bus.id_rt_addr = 11; bus.id_rd_addr = 10; bus.id_uses_rt = 1;
    bus.id_rt_data = 32'h4; bus.id_rs_data = 32'hDEAD; bus.id_shamt = 3; bus.id_alusrc1 = 1;
    bus.id_alufun = ALU_SLL; bus.id_regwrite = 1;
    step();
    chk("sll_a", bus.ex_a, 32'h3);
    chk("sll_b", bus.ex_b, 32'h4);

    // sw r7, 8(r1) with r7 forwarded from WB
    idle();
    bus.id_valid = 1; bus.id_rs_addr = 1; bus.id_rt_addr = 7; bus.id_uses_rs = 1;
    bus.id_uses_rt = 1; bus.id_rs_data = 32'h100; bus.id_imm16 = 16'h0008;
    bus.id_alusrc2 = 1; bus.id_extop = 1; bus.id_alufun = ALU_ADD; bus.id_memwrite = 1;
    step();
    bus.wb_regwrite = 1; bus.wb_rd_addr = 7; bus.wb_result = 32'hAB;
    #1 chk("sw_store", bus.ex_store_data, 32'hAB);
    chk("sw_b", bus.ex_b, 32'h8);
    chk("sw_ctrl", {29'b0, bus.ex_memread, bus.ex_memwrite, bus.ex_regwrite}, 32'h2);

    // async reset mid-cycle with a live regwrite in EX
    idle();
    bus.id_valid = 1; bus.id_rd_addr = 12; bus.id_alufun = ALU_SUB; bus.id_regwrite = 1;
    step();
    chk("pre_rst_rw", {31'b0, bus.ex_regwrite}, 32'h1);
    #2 reset = 1;
    #1 chk("arst_ctrl", {26'b0, bus.ex_valid, bus.ex_memread, bus.ex_memwrite, bus.ex_regwrite, 2'b0}, 32'h0);
    chk("arst_rd", {27'b0, bus.ex_rd_addr}, 32'h0);
    step();
    reset = 0;
    #1 chk("post_rst_valid", {31'b0, bus.ex_valid}, 32'h0);
    step();
    chk("recapture", {31'b0, bus.ex_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
